// File: rtl/rcs_pkg.sv
// Shared types and defaults for the multi-cycle ripple-carry add/subtract unit.
//   RCS_WIDTH : default operand/result width in bits
//   RCS_CHUNK : default number of bits added per clock cycle
//   state_t   : control FSM states
package rcs_pkg;

  localparam int RCS_WIDTH = 32;
  localparam int RCS_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rcs_chunk.sv
// Purely combinational CHUNK-bit ripple-carry adder slice.
//   a, b  : chunk operands
//   cin   : carry into bit 0
//   s     : chunk sum
//   cout  : carry out of the top bit
//   cmsb  : carry into the top bit (used with cout to form signed overflow)
module rcs_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic c;

  always_comb begin
    s    = '0;
    cmsb = 1'b0;
    c    = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rcs_multicycle.sv
// Multi-cycle add/subtract: one CHUNK-bit slice of the operands is added per
// cycle, LSB chunk first, so an operation takes WIDTH/CHUNK cycles.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (A, B, sub sampled on accept)
//   A, B, sub            : operands; sub=1 computes A-B, sub=0 computes A+B
//   out_valid / out_ready: result handshake; result held until consumed
//   sum, carry_out       : result and final carry (1 = no borrow when sub=1)
//   overflow, zero       : signed overflow and sum==0 flags
module rcs_multicycle
  import rcs_pkg::*;
#(
  parameter int WIDTH = RCS_WIDTH,
  parameter int CHUNK = RCS_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             cy;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nx;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             cout_c;
  logic             cmsb_c;
  logic             accept;

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Operand capture: B is pre-inverted for subtraction so the datapath only adds.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= A;
      b_q <= B ^ {WIDTH{sub}};
    end
  end

  assign a_c = a_q[int'(idx)*CHUNK +: CHUNK];
  assign b_c = b_q[int'(idx)*CHUNK +: CHUNK];

  rcs_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_c),
    .b    (b_c),
    .cin  (cy),
    .s    (s_c),
    .cout (cout_c),
    .cmsb (cmsb_c)
  );

  // Full sum as it will look once this cycle's chunk is written; lets the
  // zero flag be registered on the same edge as the final chunk.
  always_comb begin
    sum_nx = sum_q;
    sum_nx[int'(idx)*CHUNK +: CHUNK] = s_c;
  end

  // Control FSM with registered handshake and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cy        <= 1'b0;
      sum_q     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cy       <= sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q <= sum_nx;
          cy    <= cout_c;
          if (idx == LAST_IDX) begin
            carry_out <= cout_c;
            overflow  <= cout_c ^ cmsb_c;
            zero      <= (sum_nx == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_rcs_multicycle.sv
// Bench for rcs_multicycle: three instances (32/8, 8/1, 8/8) driven in lockstep
// from a vector table, hand-written hold/reset sequences and random operations.
module tb_rcs_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sub_in = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic [2:0]  ir, ov, co, of, zr;
  logic [31:0] sm0;
  logic [7:0]  sm1, sm2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  rcs_multicycle #(.WIDTH(32), .CHUNK(8)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .A(a_in), .B(b_in), .sub(sub_in), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sm0), .carry_out(co[0]), .overflow(of[0]), .zero(zr[0]));

  rcs_multicycle #(.WIDTH(8), .CHUNK(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .A(a_in[7:0]), .B(b_in[7:0]), .sub(sub_in), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sm1), .carry_out(co[1]), .overflow(of[1]), .zero(zr[1]));

  rcs_multicycle #(.WIDTH(8), .CHUNK(8)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .A(a_in[7:0]), .B(b_in[7:0]), .sub(sub_in), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sm2), .carry_out(co[2]), .overflow(of[2]), .zero(zr[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    int          hold;
    logic [31:0] sm;
    bit          co;
    bit          ov;
    bit          z;
  } vec_t;

  typedef struct {
    longint unsigned sm;
    bit              co;
    bit              ov;
    bit              z;
  } res_t;

  vec_t tab[6];
  int   widths[3] = '{32, 8, 8};
  int   lats[3]   = '{4, 8, 1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: true sum of A and (+/-)B at width w.
  function automatic res_t model(input longint unsigned a, input longint unsigned b,
                                 input bit s, input int w);
    res_t r;
    longint unsigned mask, aa, bb, full;
    bit sa, sb, ss;
    mask = (64'd1 << w) - 1;
    aa   = a & mask;
    bb   = s ? (~b & mask) : (b & mask);
    full = aa + bb + longint'(s);
    r.sm = full & mask;
    r.co = ((full >> w) & 1) != 0;
    sa   = ((aa >> (w - 1)) & 1) != 0;
    sb   = ((b >> (w - 1)) & 1) != 0;
    ss   = ((r.sm >> (w - 1)) & 1) != 0;
    r.ov = s ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    r.z  = (r.sm == 0);
    return r;
  endfunction

  function automatic logic [31:0] get_sum(input int d);
    case (d)
      0: return sm0;
      1: return {24'd0, sm1};
      default: return {24'd0, sm2};
    endcase
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int hold, input bit use_tab, input vec_t tv);
    res_t exp[3];
    bit [2:0] seen;
    for (int d = 0; d < 3; d++) exp[d] = model(a, b, s, widths[d]);
    if (use_tab) begin
      exp[0].sm = tv.sm; exp[0].co = tv.co; exp[0].ov = tv.ov; exp[0].z = tv.z;
    end
    chk("in_ready_idle", ir, 3'b111);
    a_in = a; b_in = b; sub_in = s; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    // Garbage on the inputs after accept must not leak into the result.
    in_valid = 1'b1; a_in = $urandom; b_in = $urandom; sub_in = 1'($urandom_range(0, 1));
    seen = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          chk($sformatf("latency_d%0d", d), c, lats[d]);
          chk($sformatf("sum_d%0d", d), get_sum(d), exp[d].sm);
          chk($sformatf("carry_d%0d", d), co[d], exp[d].co);
          chk($sformatf("overflow_d%0d", d), of[d], exp[d].ov);
          chk($sformatf("zero_d%0d", d), zr[d], exp[d].z);
        end
      end
      if (seen == 3'b111) break;
    end
    chk("out_valid_timeout", seen, 3'b111);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_valid", ov, 3'b111);
        chk("hold_in_ready", ir, 3'b000);
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("hold_sum_d%0d", d), get_sum(d), exp[d].sm);
          chk($sformatf("hold_flags_d%0d", d), {co[d], of[d], zr[d]},
              {exp[d].co, exp[d].ov, exp[d].z});
        end
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("consumed_valid", ov, 3'b000);
    chk("consumed_in_ready", ir, 3'b111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t none;
    none = '{a: 0, b: 0, s: 0, hold: 0, sm: 0, co: 0, ov: 0, z: 0};
    tab[0] = '{a: 32'd15,         b: 32'd10,  s: 1, hold: 0, sm: 32'd5,          co: 1, ov: 0, z: 0};
    tab[1] = '{a: 32'd100,        b: 32'd200, s: 1, hold: 0, sm: 32'hFFFFFF9C,   co: 0, ov: 0, z: 0};
    tab[2] = '{a: 32'hFFFFFFFF,   b: 32'd1,   s: 0, hold: 0, sm: 32'd0,          co: 1, ov: 0, z: 1};
    tab[3] = '{a: 32'h7FFFFFFF,   b: 32'd1,   s: 0, hold: 0, sm: 32'h80000000,   co: 0, ov: 1, z: 0};
    tab[4] = '{a: 32'd0,          b: 32'd0,   s: 1, hold: 5, sm: 32'd0,          co: 1, ov: 0, z: 1};
    tab[5] = '{a: 32'h80000000,   b: 32'd1,   s: 1, hold: 1, sm: 32'h7FFFFFFF,   co: 1, ov: 1, z: 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", ov, 3'b000);
    chk("reset_sum0", sm0, 32'd0);
    chk("reset_sum8", {sm1, sm2}, 16'd0);
    chk("reset_flags", {co, of, zr}, 9'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", ir, 3'b111);

    for (int i = 0; i < 6; i++)
      run_op(tab[i].a, tab[i].b, tab[i].s, tab[i].hold, 1'b1, tab[i]);

    // Reset in the second RUN cycle abandons the operation.
    a_in = 32'd77; b_in = 32'd11; sub_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_valid", ov, 3'b000);
    chk("midrun_reset_sum", {sm0, sm1, sm2}, 48'd0);
    chk("midrun_reset_flags", {co, of, zr}, 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      bit [2:0] any_v;
      any_v = '0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        any_v |= ov;
      end
      chk("abandoned_no_valid", any_v, 3'b000);
    end
    run_op(32'd50, 32'd25, 1'b1, 0, 1'b1,
           '{a: 32'd50, b: 32'd25, s: 1, hold: 0, sm: 32'd25, co: 1, ov: 0, z: 0});

    // Random operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) rb = ra;
      if (i % 6 == 1) ra = 32'h80000000;
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, none);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
